mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one synchronous-read data RAM between instruction fetch (IF) and the MEM stage's load/store port. It sits between those stage ports and the RAM. It serialises their accesses with fixed priority (data over fetch) and raises stall requests to the pipeline controller until each requester's access has completed. Completed read data is buffered and held until the pipeline actually advances, so a stalled pipeline never re-issues an access.

## Interface
- No parameters; widths come from the shared definitions (`RegBus` = 32 bits).
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `if_ce_i` in 1: fetch request; always a full-word read.
- `if_addr_i` in 32: fetch address.
- `if_data_o` out 32: fetched word, valid when `if_stall_o`=0 and `if_ce_i`=1.
- `if_stall_o` out 1: fetch not yet complete.
- `d_ce_i` in 1: data request.
- `d_we_i` in 1: data request is a write.
- `d_sel_i` in 4: byte selects, passed through unchanged.
- `d_addr_i` in 32: data address, passed through unchanged.
- `d_data_i` in 32: data to write.
- `d_data_o` out 32: read word, valid when `d_stall_o`=0.
- `d_stall_o` out 1: data access not yet complete.
- `stallreq_o` out 1: `if_stall_o | d_stall_o`, sent to the pipeline controller.
- `pipe_adv_i` in 1: pipeline advances this cycle. Clears both served flags.
- `flush_i` in 1: pipeline flush. Clears both served flags and discards any in-flight read.
- `ram_ce_o`, `ram_we_o` out 1 each: RAM enable and write enable.
- `ram_sel_o` out 4: RAM byte selects.
- `ram_addr_o` out 32: RAM address.
- `ram_data_o` out 32: RAM write data.
- `ram_data_i` in 32: RAM read data, valid one cycle after a read issue.

## Operation
- **Per-requester state:** one `served` flag and one 32-bit result buffer each for fetch and data.
- **Stalls:** `x_stall_o = x_ce_i & ~served_x`.
- **States:** IDLE and RD_WAIT; a 1-bit `tgt` register records which requester owns the in-flight read.

**IDLE**
- Candidates are requesters with `ce` high and `served` low. Data wins any conflict.
- Granting data: RAM outputs take `d_*`.
  - Write: `ram_we_o`=1. At the edge, set `served_d` and stay in IDLE.
  - Read: go to RD_WAIT with `tgt`=D.
- Granting fetch: RAM outputs are `ce`=1, `we`=0, `sel`=1111, `data`=0, address from `if_addr_i`. Go to RD_WAIT with `tgt`=IF.
- No grant: all RAM outputs are 0.

**RD_WAIT**
- RAM outputs are 0 and nothing new is issued.
- At the edge, capture `ram_data_i` into the `tgt` buffer, set `served_tgt`, and return to IDLE.
- If `flush_i`=1 in this cycle: do not capture and do not set `served`; still return to IDLE.

**Flags and outputs**
- `pipe_adv_i` or `flush_i` clears both `served` flags. Clearing has priority over setting in the same cycle.
- `if_data_o` and `d_data_o` are driven from their buffers. Buffers change only on capture.
- A requester that drops `ce` while `served` stays set does not stall; the flag clears on the next advance or flush.

**Reset:** state is forced to IDLE. Both flags and both buffers are cleared to 0, and all outputs are 0, including stalls. A read in flight when reset is applied is abandoned.

## Timing
- **Data read:** issue at t0, capture at t1, `d_stall_o`=0 with valid data at t2. Two stall cycles.
- **Data write:** issue at t0, RAM writes at the t0 edge, `d_stall_o`=0 at t1. One stall cycle.
- **Fetch:** same as a data read. When both request together, fetch issues at t2 and its data is valid at t4.
- **Held results:** after completion, results stay valid and no re-issue occurs until `pipe_adv_i` or `flush_i`.
- **Clear-then-request:** after a clear, a still-asserted `ce` is treated as a new request on the next cycle.
- **Combinational paths:** `ram_*` outputs depend combinationally on state, `d_*`/`if_*` inputs and the flags. Stall outputs depend combinationally on `ce` and the flags.

## Structure
- **Shared package / defines:**
  - state encoding `ARB_IDLE`, `ARB_RD_WAIT`
  - target encoding `ARB_TGT_IF`, `ARB_TGT_D`
  - existing `ChipEnable`, `WriteEnable` and `ZeroWord`
- **Sub-module `mem_arb_port`** (instantiated twice, fetch and data): holds the `served` flag, the 32-bit buffer and the stall logic, with inputs `set`, `clr`, `capture_data`. The arbiter top holds the FSM, grant logic and RAM mux.

## Test plan
- **Data read:** `d_ce`=1, `we`=0, `addr`=0x100, RAM returns 0xDEADBEEF at t1 → `d_stall_o` 1,1,0; `d_data_o`=0xDEADBEEF at t2; `ram_ce_o` high only at t0.
- **Data write:** `d_we`=1, `sel`=0011, `data`=0x0000BEEF, `addr`=0x104 → one RAM write cycle with those values; `d_stall_o` 1,0.
- **Conflict:** fetch 0x0 and data read 0x200 asserted together → RAM address 0x200 at t0, 0x0 at t2; `stallreq_o` low first at t4 with both results valid.
- **Hold:** after completion, `pipe_adv_i`=0 for 3 cycles → `ram_ce_o` stays 0 and outputs are stable. Then `pipe_adv_i`=1 → flags cleared and a new request issues next cycle.
- **Flush in RD_WAIT:** `flush_i`=1 at t1 → no capture; old buffer value retained; FSM in IDLE at t2.
- **Reset in RD_WAIT:** `rst`=1 at t1 → IDLE; all outputs 0; a request asserted after reset issues normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared widths, enables and FSM/target encodings for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int RegBus = 32;

    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord = {RegBus{1'b0}};

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_TGT_IF = 1'b0,
        ARB_TGT_D  = 1'b1
    } arb_tgt_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_port.sv
// ============================================================================
// Module   : mem_arb_port
// Purpose  : Per-requester served flag, result buffer and stall generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_port
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              cap_en_i,
    input  logic [RegBus-1:0] capture_data_i,
    output logic              served_o,
    output logic              stall_o,
    output logic [RegBus-1:0] data_o
);

    logic              served_q, served_d;
    logic [RegBus-1:0] buf_q, buf_d;

    // A pipeline advance or flush wins over a completion in the same cycle.
    always_comb begin
        served_d = served_q;
        if (clr_i) begin
            served_d = 1'b0;
        end else if (set_i) begin
            served_d = 1'b1;
        end
        buf_d = cap_en_i ? capture_data_i : buf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            served_q <= 1'b0;
            buf_q    <= ZeroWord;
        end else begin
            served_q <= served_d;
            buf_q    <= buf_d;
        end
    end

    assign served_o = served_q;
    assign stall_o  = ce_i & ~served_q & ~rst;
    assign data_o   = rst ? ZeroWord : buf_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one synchronous-read RAM between fetch and load/store,
//            data port first, holding results until the pipeline advances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_ce_i,
    input  logic [RegBus-1:0] if_addr_i,
    output logic [RegBus-1:0] if_data_o,
    output logic              if_stall_o,

    input  logic              d_ce_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [RegBus-1:0] d_addr_i,
    input  logic [RegBus-1:0] d_data_i,
    output logic [RegBus-1:0] d_data_o,
    output logic              d_stall_o,

    output logic              stallreq_o,
    input  logic              pipe_adv_i,
    input  logic              flush_i,

    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [RegBus-1:0] ram_addr_o,
    output logic [RegBus-1:0] ram_data_o,
    input  logic [RegBus-1:0] ram_data_i
);

    arb_state_e state_q, state_d;
    arb_tgt_e   tgt_q, tgt_d;

    logic if_served, d_served;
    logic if_set, if_cap, d_set, d_cap;
    logic clr;

    assign clr = pipe_adv_i | flush_i;

    mem_arb_port u_if_port (
        .clk            (clk),
        .rst            (rst),
        .ce_i           (if_ce_i),
        .set_i          (if_set),
        .clr_i          (clr),
        .cap_en_i       (if_cap),
        .capture_data_i (ram_data_i),
        .served_o       (if_served),
        .stall_o        (if_stall_o),
        .data_o         (if_data_o)
    );

    mem_arb_port u_d_port (
        .clk            (clk),
        .rst            (rst),
        .ce_i           (d_ce_i),
        .set_i          (d_set),
        .clr_i          (clr),
        .cap_en_i       (d_cap),
        .capture_data_i (ram_data_i),
        .served_o       (d_served),
        .stall_o        (d_stall_o),
        .data_o         (d_data_o)
    );

    assign stallreq_o = if_stall_o | d_stall_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            tgt_q   <= ARB_TGT_IF;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_sel_o  = 4'b0000;
        ram_addr_o = ZeroWord;
        ram_data_o = ZeroWord;
        if_set     = 1'b0;
        if_cap     = 1'b0;
        d_set      = 1'b0;
        d_cap      = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (d_ce_i && !d_served) begin
                    ram_ce_o   = ChipEnable;
                    ram_we_o   = d_we_i;
                    ram_sel_o  = d_sel_i;
                    ram_addr_o = d_addr_i;
                    ram_data_o = d_data_i;
                    // Writes complete at the issue edge; reads need the RAM latency.
                    if (d_we_i == WriteEnable) begin
                        d_set = 1'b1;
                    end else begin
                        state_d = ARB_RD_WAIT;
                        tgt_d   = ARB_TGT_D;
                    end
                end else if (if_ce_i && !if_served) begin
                    ram_ce_o   = ChipEnable;
                    ram_sel_o  = 4'b1111;
                    ram_addr_o = if_addr_i;
                    state_d    = ARB_RD_WAIT;
                    tgt_d      = ARB_TGT_IF;
                end
            end
            ARB_RD_WAIT: begin
                state_d = ARB_IDLE;
                if (!flush_i) begin
                    if (tgt_q == ARB_TGT_D) begin
                        d_cap = 1'b1;
                        d_set = 1'b1;
                    end else begin
                        if_cap = 1'b1;
                        if_set = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (rst) begin
            ram_ce_o   = 1'b0;
            ram_we_o   = 1'b0;
            ram_sel_o  = 4'b0000;
            ram_addr_o = ZeroWord;
            ram_data_o = ZeroWord;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and randomised self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stall_o;
    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_stall_o;
    logic        stallreq_o;
    logic        pipe_adv_i;
    logic        flush_i;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    int total = 0;
    int bad   = 0;
    int n_issue = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] rdata_q;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_ce_i    (if_ce_i),
        .if_addr_i  (if_addr_i),
        .if_data_o  (if_data_o),
        .if_stall_o (if_stall_o),
        .d_ce_i     (d_ce_i),
        .d_we_i     (d_we_i),
        .d_sel_i    (d_sel_i),
        .d_addr_i   (d_addr_i),
        .d_data_i   (d_data_i),
        .d_data_o   (d_data_o),
        .d_stall_o  (d_stall_o),
        .stallreq_o (stallreq_o),
        .pipe_adv_i (pipe_adv_i),
        .flush_i    (flush_i),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_sel_o  (ram_sel_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM with byte-enabled writes, driven by the DUT pins.
    always @(posedge clk) begin
        if (ram_ce_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel_o[b]) mem[ram_addr_o[11:2]][b*8 +: 8] = ram_data_o[b*8 +: 8];
            end else begin
                rdata_q <= mem[ram_addr_o[11:2]];
            end
        end
    end

    always @(posedge clk) if (ram_ce_o) n_issue <= n_issue + 1;

    assign ram_data_i = rdata_q;

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preset(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    task automatic adv();
        if_ce_i    = 1'b0;
        d_ce_i     = 1'b0;
        d_we_i     = 1'b0;
        pipe_adv_i = 1'b1;
        tick();
        pipe_adv_i = 1'b0;
    endtask

    initial begin : main
        int          kind, didx, fidx, start, d_done, f_done, hold;
        bit          need_d, need_f, wr;
        int          exp_d_lat, exp_f_lat;
        logic [31:0] exp_d_val, exp_f_val, wval;
        logic [3:0]  wsel;

        for (int i = 0; i < 1024; i++) preset(i, 32'h0);
        rst = 1'b1; if_ce_i = 0; if_addr_i = 0; d_ce_i = 0; d_we_i = 0;
        d_sel_i = 0; d_addr_i = 0; d_data_i = 0; pipe_adv_i = 0; flush_i = 0;
        tick(); tick();

        // Reset state
        chk("rst_stallreq", {31'b0, stallreq_o}, 32'd0);
        chk("rst_ram_ce",   {31'b0, ram_ce_o}, 32'd0);
        rst = 1'b0; settle();
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_d_data",  d_data_o, 32'h0);
        chk("rst_stalls",  {29'b0, if_stall_o, d_stall_o, stallreq_o}, 32'd0);

        // Data read
        preset(32'h40, 32'hDEADBEEF);
        d_ce_i = 1; d_we_i = 0; d_addr_i = 32'h100; d_sel_i = 4'hF; settle();
        chk("rd_t0_stall", {31'b0, d_stall_o}, 32'd1);
        chk("rd_t0_ramce", {31'b0, ram_ce_o}, 32'd1);
        chk("rd_t0_addr",  ram_addr_o, 32'h100);
        tick();
        chk("rd_t1_stall", {31'b0, d_stall_o}, 32'd1);
        chk("rd_t1_ramce", {31'b0, ram_ce_o}, 32'd0);
        tick();
        chk("rd_t2_stall", {31'b0, d_stall_o}, 32'd0);
        chk("rd_t2_data",  d_data_o, 32'hDEADBEEF);
        chk("rd_t2_ramce", {31'b0, ram_ce_o}, 32'd0);
        adv();

        // Data write
        preset(32'h41, 32'h12345678);
        d_ce_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_data_i = 32'h0000BEEF; d_addr_i = 32'h104;
        settle();
        chk("wr_t0_stall", {31'b0, d_stall_o}, 32'd1);
        chk("wr_t0_we",    {31'b0, ram_we_o}, 32'd1);
        chk("wr_t0_sel",   {28'b0, ram_sel_o}, 32'h3);
        chk("wr_t0_data",  ram_data_o, 32'h0000BEEF);
        chk("wr_t0_addr",  ram_addr_o, 32'h104);
        tick();
        chk("wr_t1_stall", {31'b0, d_stall_o}, 32'd0);
        chk("wr_t1_ramce", {31'b0, ram_ce_o}, 32'd0);
        chk("wr_mem",      mem[32'h41], 32'h1234BEEF);
        ref_mem[32'h41] = 32'h1234BEEF;
        adv();

        // Fetch and data read together
        preset(0, 32'hA5A50001);
        preset(32'h80, 32'h0BADF00D);
        if_ce_i = 1; if_addr_i = 32'h0; d_ce_i = 1; d_we_i = 0; d_sel_i = 4'hF; d_addr_i = 32'h200;
        settle();
        chk("cf_t0_addr",     ram_addr_o, 32'h200);
        chk("cf_t0_stallreq", {31'b0, stallreq_o}, 32'd1);
        tick();
        chk("cf_t1_stallreq", {31'b0, stallreq_o}, 32'd1);
        chk("cf_t1_ramce",    {31'b0, ram_ce_o}, 32'd0);
        tick();
        chk("cf_t2_ramce",    {31'b0, ram_ce_o}, 32'd1);
        chk("cf_t2_addr",     ram_addr_o, 32'h0);
        chk("cf_t2_stalls",   {30'b0, if_stall_o, d_stall_o}, 32'b10);
        tick();
        chk("cf_t3_stallreq", {31'b0, stallreq_o}, 32'd1);
        tick();
        chk("cf_t4_stallreq", {31'b0, stallreq_o}, 32'd0);
        chk("cf_t4_if_data",  if_data_o, 32'hA5A50001);
        chk("cf_t4_d_data",   d_data_o, 32'h0BADF00D);

        // Hold: no re-issue while the pipeline is stalled
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ramce",    {31'b0, ram_ce_o}, 32'd0);
            chk("hold_stallreq", {31'b0, stallreq_o}, 32'd0);
            chk("hold_d_data",   d_data_o, 32'h0BADF00D);
            chk("hold_if_data",  if_data_o, 32'hA5A50001);
        end
        pipe_adv_i = 1; settle();
        chk("hold_adv_ramce", {31'b0, ram_ce_o}, 32'd0);
        tick();
        pipe_adv_i = 0; settle();
        chk("hold_new_ramce", {31'b0, ram_ce_o}, 32'd1);
        chk("hold_new_addr",  ram_addr_o, 32'h200);
        chk("hold_new_stall", {31'b0, d_stall_o}, 32'd1);
        tick(); tick(); tick(); tick();
        chk("hold_new_done",  {31'b0, stallreq_o}, 32'd0);
        adv();

        // Flush while a read is in flight
        preset(32'h90, 32'h11112222);
        d_ce_i = 1; d_we_i = 0; d_addr_i = 32'h240; settle();
        tick();
        flush_i = 1; settle();
        chk("fl_t1_stall", {31'b0, d_stall_o}, 32'd1);
        tick();
        flush_i = 0; settle();
        chk("fl_t2_data",  d_data_o, 32'h0BADF00D);
        chk("fl_t2_ramce", {31'b0, ram_ce_o}, 32'd1);
        chk("fl_t2_stall", {31'b0, d_stall_o}, 32'd1);
        tick(); tick();
        chk("fl_done_stall", {31'b0, d_stall_o}, 32'd0);
        chk("fl_done_data",  d_data_o, 32'h11112222);
        adv();

        // Reset while a fetch is in flight
        if_ce_i = 1; if_addr_i = 32'h0; settle();
        chk("rs_t0_ramce", {31'b0, ram_ce_o}, 32'd1);
        tick();
        rst = 1; settle();
        chk("rs_t1_stalls", {29'b0, if_stall_o, d_stall_o, stallreq_o}, 32'd0);
        chk("rs_t1_ramce",  {31'b0, ram_ce_o}, 32'd0);
        chk("rs_t1_if_data", if_data_o, 32'h0);
        chk("rs_t1_d_data",  d_data_o, 32'h0);
        tick();
        rst = 0; settle();
        chk("rs_t2_ramce",  {31'b0, ram_ce_o}, 32'd1);
        chk("rs_t2_addr",   ram_addr_o, 32'h0);
        chk("rs_t2_stall",  {31'b0, if_stall_o}, 32'd1);
        chk("rs_t2_d_data", d_data_o, 32'h0);
        tick(); tick();
        chk("rs_done_stall", {31'b0, if_stall_o}, 32'd0);
        chk("rs_done_data",  if_data_o, 32'hA5A50001);
        adv();

        // Randomised transactions against a transaction-level model
        for (int it = 0; it < 40; it++) begin
            kind   = int'($urandom_range(0, 2));
            need_d = (kind != 1);
            need_f = (kind != 0);
            wr     = need_d && ($urandom_range(0, 1) == 1);
            didx   = int'($urandom_range(0, 255));
            fidx   = int'($urandom_range(0, 255));
            wsel   = 4'($urandom_range(1, 15));
            wval   = $urandom;
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (wsel[b]) ref_mem[didx][b*8 +: 8] = wval[b*8 +: 8];
            exp_d_lat = wr ? 1 : 2;
            exp_f_lat = need_d ? exp_d_lat + 2 : 2;
            exp_d_val = ref_mem[didx];
            exp_f_val = ref_mem[fidx];

            start     = n_issue;
            d_ce_i    = need_d;
            d_we_i    = wr;
            d_sel_i   = wr ? wsel : 4'hF;
            d_addr_i  = didx << 2;
            d_data_i  = wr ? wval : 32'h0;
            if_ce_i   = need_f;
            if_addr_i = fidx << 2;
            settle();
            d_done = -1;
            f_done = -1;
            for (int cyc = 0; cyc < 12; cyc++) begin
                if (need_d && d_done < 0 && !d_stall_o) d_done = cyc;
                if (need_f && f_done < 0 && !if_stall_o) f_done = cyc;
                if ((!need_d || d_done >= 0) && (!need_f || f_done >= 0)) break;
                tick();
            end
            if (need_d) chk("rnd_d_latency", 32'(d_done), 32'(exp_d_lat));
            if (need_d && !wr) chk("rnd_d_data", d_data_o, exp_d_val);
            if (need_f) chk("rnd_f_latency", 32'(f_done), 32'(exp_f_lat));
            if (need_f) chk("rnd_f_data", if_data_o, exp_f_val);
            hold = int'($urandom_range(0, 2));
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("rnd_hold_stallreq", {31'b0, stallreq_o}, 32'd0);
            end
            chk("rnd_issue_count", 32'(n_issue - start), 32'(int'(need_d) + int'(need_f)));
            adv();
        end

        // Written data must have landed exactly as the model predicts
        for (int i = 0; i < 256; i += 17) chk("rnd_mem_image", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
